// File: rtl/decade_counter.sv
// Single BCD decade digit with enable, terminal count for cascading, and synchronous reset.
// Optional parallel load (load, load_value) is compiled in when DECADE_COUNTER_LOAD_EN is defined.
module decade_counter #(
  parameter logic [3:0] RESET_VALUE = 4'd0
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       en,
`ifdef DECADE_COUNTER_LOAD_EN
  input  logic       load,
  input  logic [3:0] load_value,
`endif
  output logic [3:0] count,
  output logic       tc
);

  localparam logic [3:0] MaxCount = 4'd9;

  if (RESET_VALUE > MaxCount) begin : gen_bad_reset_value
    $error("decade_counter: RESET_VALUE must be in 0..9");
  end

  logic [3:0] count_q, count_d;
  logic       load_hit;
  logic [3:0] load_data;

`ifdef DECADE_COUNTER_LOAD_EN
  assign load_hit  = load;
  assign load_data = (load_value > MaxCount) ? 4'd0 : load_value;
`else
  assign load_hit  = 1'b0;
  assign load_data = 4'd0;
`endif

  // Illegal codes recover to zero even while disabled; load still wins over recovery.
  always_comb begin
    count_d = count_q;
    if (load_hit) begin
      count_d = load_data;
    end else if (count_q > MaxCount) begin
      count_d = 4'd0;
    end else if (en) begin
      count_d = (count_q == MaxCount) ? 4'd0 : count_q + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      count_q <= RESET_VALUE;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == MaxCount) && en && !load_hit;

endmodule

// File: tb/tb_decade_counter.sv
// Scoreboard bench for decade_counter: expected counts are queued as stimulus is driven
// and popped when the register updates; load tests run only with DECADE_COUNTER_LOAD_EN.
module tb_decade_counter;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] count;
  logic       tc;
`ifdef DECADE_COUNTER_LOAD_EN
  logic       load;
  logic [3:0] load_value;
`endif

  int unsigned total = 0;
  int unsigned bad = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  mdl;
  time         wrap_t[$];

  always #5 clock = ~clock;

  decade_counter dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .en         (en),
`ifdef DECADE_COUNTER_LOAD_EN
    .load       (load),
    .load_value (load_value),
`endif
    .count      (count),
    .tc         (tc)
  );

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs away from the edge, check tc, queue the next count, then
  // compare the registered count just after the rising edge.
  task automatic step(input logic r, input logic e, input logic ld, input logic [3:0] lv,
                      input string tag);
    logic [3:0] nxt;
    logic [3:0] got_exp;
    rst_n = r;
    en    = e;
`ifdef DECADE_COUNTER_LOAD_EN
    load       = ld;
    load_value = lv;
`endif
    #2;
    if (!$isunknown(mdl)) begin
      check_val({tag, "_tc"}, {7'd0, tc}, {7'd0, (mdl == 4'd9) && e && !ld});
    end
    if (!r)             nxt = 4'd0;
    else if (ld)        nxt = (lv > 4'd9) ? 4'd0 : lv;
    else if (mdl > 4'd9) nxt = 4'd0;
    else if (e)         nxt = (mdl == 4'd9) ? 4'd0 : mdl + 4'd1;
    else                nxt = mdl;
    exp_q.push_back(nxt);
    @(posedge clock);
    #1;
    got_exp = exp_q.pop_front();
    check_val({tag, "_cnt"}, {4'd0, count}, {4'd0, got_exp});
    mdl = got_exp;
  endtask

  initial begin
    mdl   = 'x;
    rst_n = 1'b0;
    en    = 1'b1;
`ifdef DECADE_COUNTER_LOAD_EN
    load       = 1'b0;
    load_value = 4'd0;
`endif

    // Reset held for two edges with en high.
    step(1'b0, 1'b1, 1'b0, 4'd0, "rst");
    step(1'b0, 1'b1, 1'b0, 4'd0, "rst");
    check_val("rst_tc_low", {7'd0, tc}, 8'd0);

    // Count 12 edges: 1..9,0,1,2 against a fixed sequence as well as the model.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0, 4'd0, "count");
      check_val("count_seq", {4'd0, count}, 8'((i + 1) % 10));
    end

    // Hold at 5 for 10 edges, then one enabled edge to 6.
    step(1'b0, 1'b1, 1'b0, 4'd0, "rst2");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 4'd0, "to5");
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 4'd0, "hold");
      check_val("hold_val", {4'd0, count}, 8'd5);
    end
    step(1'b1, 1'b1, 1'b0, 4'd0, "resume");
    check_val("resume_val", {4'd0, count}, 8'd6);

    // Mid-count reset from 7.
    step(1'b1, 1'b1, 1'b0, 4'd0, "to7");
    step(1'b0, 1'b1, 1'b0, 4'd0, "midrst");
    check_val("midrst_val", {4'd0, count}, 8'd0);
    step(1'b1, 1'b1, 1'b0, 4'd0, "after_rst");
    check_val("after_rst_val", {4'd0, count}, 8'd1);

`ifdef DECADE_COUNTER_LOAD_EN
    step(1'b1, 1'b1, 1'b1, 4'd8, "load8");
    step(1'b1, 1'b1, 1'b0, 4'd0, "to9");
    check_val("at9_tc", {7'd0, tc}, 8'd1);
    step(1'b1, 1'b1, 1'b0, 4'd0, "wrap");
    step(1'b1, 1'b1, 1'b1, 4'd8, "load8b");
    step(1'b1, 1'b1, 1'b0, 4'd0, "to9b");
    step(1'b1, 1'b1, 1'b1, 4'd12, "load12");
    check_val("load12_val", {4'd0, count}, 8'd0);
`endif

    // Startup: reset, en low for 20 units, then free-running; wraps 100 units apart.
    step(1'b0, 1'b0, 1'b0, 4'd0, "su_rst");
    step(1'b1, 1'b0, 1'b0, 4'd0, "su_idle");
    step(1'b1, 1'b0, 1'b0, 4'd0, "su_idle");
    for (int i = 0; i < 25; i++) begin
      step(1'b1, 1'b1, 1'b0, 4'd0, "su_run");
      if (mdl == 4'd0) wrap_t.push_back($time);
    end
    if (wrap_t.size() >= 2) begin
      check_val("wrap_period", 8'(wrap_t[1] - wrap_t[0]), 8'd100);
    end else begin
      check_val("wrap_seen", 8'(wrap_t.size()), 8'd2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decade_counter.md
DECADE_COUNTER -- requirements
Module: decade_counter

Interface
REQ-001 SHALL have parameter RESET_VALUE, default 4'd0, meaning the count loaded on reset; legal range 0..9.
REQ-002 SHALL have port clock, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, meaning the synchronous, active-low reset.
REQ-004 SHALL have port en, input, 1 bit, meaning count enable; active-high.
REQ-005 SHALL have port count, output, 4 bits, meaning the registered BCD count value 0..9.
REQ-006 SHALL have port tc, output, 1 bit, meaning terminal count; combinational, 1 when count==9 and en==1.
REQ-007 SHALL have port load, input, 1 bit, meaning synchronous parallel-load strobe; present only with DECADE_COUNTER_LOAD_EN.
REQ-008 SHALL have port load_value, input, 4 bits, meaning the value to load; present only with DECADE_COUNTER_LOAD_EN.

Function
REQ-009 SHALL increment count by 1 on each rising clock edge where rst_n==1 and en==1, with count<9.
REQ-010 SHALL wrap count from 9 to 0 on a rising edge where en==1; it SHALL never present 10..15 in normal operation.
REQ-011 SHALL hold count unchanged on a rising edge where en==0.
REQ-012 SHALL drive tc=1 in the same cycle that count==9 and en==1, and tc=0 otherwise, enabling cascaded digits via next_digit.en = tc.
REQ-013 SHALL force count to 0 on the next rising edge if it ever holds an illegal value 10..15, e.g. from an X-resolution upset, regardless of en.
REQ-014 SHALL have a latency of one clock from en sampled high to the updated count; there is no pipeline beyond the count register.
REQ-015 SHALL make count a pure register output with no combinational path from en to count.

Reset
REQ-016 SHALL load count with RESET_VALUE on a rising edge where rst_n==0, overriding en and load.
REQ-017 SHALL leave reset purely synchronous: a change in rst_n between edges SHALL have no effect on count.
REQ-018 SHALL drive tc=0 while count holds RESET_VALUE unless RESET_VALUE==9 and en==1.
REQ-019 SHALL apply reset mid-count with the same result, returning count to RESET_VALUE on that edge.
REQ-020 SHALL treat RESET_VALUE>9 as an elaboration error.

Configuration
REQ-021 SHALL compile in ports load and load_value when macro DECADE_COUNTER_LOAD_EN is defined.
REQ-022 SHALL, with DECADE_COUNTER_LOAD_EN defined, load count with load_value on a rising edge where rst_n==1 and load==1, taking priority over en.
REQ-023 SHALL, on a load where load_value>9, load 0.
REQ-024 SHALL, with DECADE_COUNTER_LOAD_EN defined, force tc=0 in any cycle where load==1.
REQ-025 SHALL omit both ports when DECADE_COUNTER_LOAD_EN is undefined, with all other behaviour identical.

Verification
REQ-026 SHALL cover reset: rst_n=0 for 2 edges with en=1 -> count=0 and tc=0.
REQ-027 SHALL cover counting: rst_n=1, en=1 for 12 edges -> count sequence 1,2,...,9,0,1,2, with tc=1 only during the count==9 cycle.
REQ-028 SHALL cover hold: count=5, en=0 for 10 edges -> count stays 5 and tc=0; then en=1 -> count 6 after one edge.
REQ-029 SHALL cover mid-count reset: count=7, en=1, rst_n=0 for one edge -> count=0; rst_n=1 -> count 1 on the next edge.
REQ-030 SHALL cover load, with the macro defined: load=1, load_value=8, en=1 -> count=8; next edge, load=0 -> 9 with tc=1; next edge -> 0. Also load_value=12 -> count=0.
REQ-031 SHALL cover startup: en=0 for 20 time units, then en=1, 5-unit half-period clock, after reset -> count increments every 10 units and wraps every 100 units.
